// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vender.
// Holds the controller state encoding and the per-product price lookup.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CREDIT   = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } vend_state_e;

   localparam int PSEL_W       = 3;
   localparam int MAX_PRODUCTS = 7;
   localparam int PRICE_W_MAX  = 8;
   localparam int PRICE_VEC_W  = MAX_PRODUCTS * PRICE_W_MAX;

   // Price table is packed little-end first: slice idx holds product idx's price.
   function automatic logic [PRICE_W_MAX-1:0] price_of(
      input logic [PRICE_VEC_W-1:0] prices,
      input int unsigned            idx,
      input int unsigned            cw
   );
      logic [PRICE_VEC_W-1:0] shifted;
      logic [PRICE_W_MAX-1:0] mask;
      shifted = prices >> (idx * cw);
      mask    = PRICE_W_MAX'((32'd1 << cw) - 32'd1);
      return PRICE_W_MAX'(shifted) & mask;
   endfunction

endpackage

// File: rtl/vend_select.sv
// Button priority encoder with affordability check: the lowest-index pressed
// button is the only candidate, and hit says whether current credit covers it.
module vend_select
   import vend_pkg::*;
#(
   parameter int NUM_PRODUCTS = 3,
   parameter int CREDIT_W     = 4
) (
   input  logic [NUM_PRODUCTS-1:0]          button,
   input  logic [CREDIT_W-1:0]              credit,
   input  logic [NUM_PRODUCTS*CREDIT_W-1:0] prices,
   output logic                             hit,
   output logic [PSEL_W-1:0]                idx
);

   logic                   found;
   logic [PRICE_W_MAX-1:0] cand_price;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (button[i] && !found) begin
            found = 1'b1;
            idx   = PSEL_W'(i);
         end
      end
      // Higher-index buttons never get a second chance if the candidate is too dear.
      cand_price = price_of(PRICE_VEC_W'(prices), 32'(idx), CREDIT_W);
      hit        = found && (cand_price <= PRICE_W_MAX'(credit));
   end

endmodule

// File: rtl/vend_multi.sv
// Multi-product vending controller: credit, dispense, then token-by-token change.
// Optional refund/cancel input is compiled in with VEND_REFUND_EN.
module vend_multi
   import vend_pkg::*;
#(
   parameter int                             NUM_PRODUCTS = 3,
   parameter int                             CREDIT_W     = 4,
   parameter int                             MAX_CREDIT   = 7,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES     = {4'd3, 4'd2, 4'd1}
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    token_in,
   input  logic [NUM_PRODUCTS-1:0] button,
   input  logic                    dispense_done,
   input  logic                    change_ready,
`ifdef VEND_REFUND_EN
   input  logic                    refund,
`endif
   output logic [PSEL_W-1:0]       product_select,
   output logic                    change_valid,
   output logic                    token_reject,
   output logic [CREDIT_W-1:0]     credit,
   output logic                    busy,
   output logic [1:0]              state_dbg
);

   // Change handshake: a token leaves the hopper on every cycle where
   // change_valid and change_ready are both high; change_valid holds until then.

   localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] ONE_C = CREDIT_W'(1);

   vend_state_e          state_q;
   logic [CREDIT_W-1:0]  credit_q;
   logic [PSEL_W-1:0]    psel_q;
   logic                 cv_q;
   logic                 rej_q;
   logic                 busy_q;

   logic                 sel_hit;
   logic [PSEL_W-1:0]    sel_idx;
   logic [CREDIT_W-1:0]  sel_price;
   logic                 refund_req;
   logic                 tok_accept;
   logic [CREDIT_W-1:0]  credit_tok_d;

`ifdef VEND_REFUND_EN
   assign refund_req = refund;
`else
   assign refund_req = 1'b0;
`endif

   vend_select #(
      .NUM_PRODUCTS (NUM_PRODUCTS),
      .CREDIT_W     (CREDIT_W)
   ) u_select (
      .button (button),
      .credit (credit_q),
      .prices (PRICES),
      .hit    (sel_hit),
      .idx    (sel_idx)
   );

   assign sel_price    = CREDIT_W'(price_of(PRICE_VEC_W'(PRICES), 32'(sel_idx), CREDIT_W));
   assign tok_accept   = token_in && (credit_q < MAX_C);
   assign credit_tok_d = tok_accept ? credit_q + ONE_C : credit_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         credit_q <= '0;
         psel_q   <= '0;
         cv_q     <= 1'b0;
         rej_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         rej_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (token_in) begin
                  credit_q <= ONE_C;
                  state_q  <= CREDIT;
               end
            end
            CREDIT: begin
               credit_q <= credit_tok_d;
               if (token_in && !tok_accept) begin
                  rej_q <= 1'b1;
               end
               // A same-cycle token is credited before refund; it also masks buttons.
               if (refund_req) begin
                  state_q <= CHANGE;
                  cv_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (!token_in && sel_hit) begin
                  credit_q <= credit_q - sel_price;
                  psel_q   <= sel_idx + PSEL_W'(1);
                  state_q  <= DISPENSE;
                  busy_q   <= 1'b1;
               end
            end
            DISPENSE: begin
               if (token_in) begin
                  rej_q <= 1'b1;
               end
               if (dispense_done) begin
                  psel_q <= '0;
                  if (credit_q != '0) begin
                     state_q <= CHANGE;
                     cv_q    <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            CHANGE: begin
               if (token_in) begin
                  rej_q <= 1'b1;
               end
               if (cv_q && change_ready) begin
                  credit_q <= credit_q - ONE_C;
                  if (credit_q == ONE_C) begin
                     cv_q    <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign product_select = psel_q;
   assign change_valid   = cv_q;
   assign token_reject   = rej_q;
   assign credit         = credit_q;
   assign busy           = busy_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_vend_multi.sv
// Self-checking bench for vend_multi: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level model of the vender.
module tb_vend_multi;

   localparam int NP   = 3;
   localparam int CW   = 4;
   localparam int MAXC = 7;
   localparam logic [NP*CW-1:0] PR = {4'd3, 4'd2, 4'd1};
   localparam int OW   = 2 + 3 + 1 + 1 + CW + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          token_in = 1'b0;
   logic [NP-1:0] button = '0;
   logic          dispense_done = 1'b0;
   logic          change_ready = 1'b0;
   logic          refund = 1'b0;
   logic [2:0]    product_select;
   logic          change_valid;
   logic          token_reject;
   logic [CW-1:0] credit;
   logic          busy;
   logic [1:0]    state_dbg;

   vend_multi #(
      .NUM_PRODUCTS (NP),
      .CREDIT_W     (CW),
      .MAX_CREDIT   (MAXC),
      .PRICES       (PR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .token_in       (token_in),
      .button         (button),
      .dispense_done  (dispense_done),
      .change_ready   (change_ready),
`ifdef VEND_REFUND_EN
      .refund         (refund),
`endif
      .product_select (product_select),
      .change_valid   (change_valid),
      .token_reject   (token_reject),
      .credit         (credit),
      .busy           (busy),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int  price_tbl[NP] = '{1, 2, 3};
   int  m_credit;
   int  m_holding;     // product number being dispensed (1-based), 0 if none
   bit  m_returning;   // change is being paid out
   bit  m_reject;

   logic [OW-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   function automatic void model_reset();
      m_credit    = 0;
      m_holding   = 0;
      m_returning = 1'b0;
      m_reject    = 1'b0;
   endfunction

   function automatic void model_step(input bit tok, input logic [NP-1:0] btn,
                                      input bit done, input bit rdy, input bit rf);
      int cand;
      m_reject = 1'b0;
      if (m_returning) begin
         if (tok) m_reject = 1'b1;
         if (rdy && m_credit > 0) m_credit = m_credit - 1;
         if (m_credit == 0) m_returning = 1'b0;
      end else if (m_holding != 0) begin
         if (tok) m_reject = 1'b1;
         if (done) begin
            m_holding = 0;
            if (m_credit > 0) m_returning = 1'b1;
         end
      end else if (m_credit == 0) begin
         if (tok) m_credit = 1;
      end else begin
         if (tok) begin
            if (m_credit < MAXC) m_credit = m_credit + 1;
            else m_reject = 1'b1;
         end
         if (rf) begin
            m_returning = 1'b1;
         end else if (!tok && btn != 0) begin
            cand = -1;
            for (int i = 0; i < NP; i++) begin
               if (btn[i] && cand < 0) cand = i;
            end
            if (price_tbl[cand] <= m_credit) begin
               m_credit  = m_credit - price_tbl[cand];
               m_holding = cand + 1;
            end
         end
      end
   endfunction

   function automatic logic [OW-1:0] model_outputs();
      int  mode;
      logic [1:0] mode_v;
      logic [2:0] hold_v;
      logic [CW-1:0] cred_v;
      if (m_returning) mode = 3;
      else if (m_holding != 0) mode = 2;
      else if (m_credit > 0) mode = 1;
      else mode = 0;
      mode_v = 2'(mode);
      hold_v = 3'(m_holding);
      cred_v = CW'(m_credit);
      return {mode_v, hold_v, (m_returning && m_credit > 0), m_reject, cred_v,
              (m_holding != 0 || m_returning)};
   endfunction

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit tok, input logic [NP-1:0] btn, input bit done,
                        input bit rdy, input bit rf);
      @(negedge clk);
      token_in      = tok;
      button        = btn;
      dispense_done = done;
      change_ready  = rdy;
      refund        = rf;
      @(posedge clk);
      model_step(tok, btn, done, rdy, rf);
      exp_q.push_back(model_outputs());
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tokens(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic async_reset_check(input string tag);
      @(negedge clk);
      #2;
      reset         = 1'b1;
      token_in      = 1'b0;
      button        = '0;
      dispense_done = 1'b0;
      change_ready  = 1'b0;
      refund        = 1'b0;
      #1;
      check({tag, "_psel"},   int'(product_select), 0);
      check({tag, "_cv"},     int'(change_valid),   0);
      check({tag, "_rej"},    int'(token_reject),   0);
      check({tag, "_credit"}, int'(credit),         0);
      check({tag, "_busy"},   int'(busy),           0);
      check({tag, "_state"},  int'(state_dbg),      0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [OW-1:0] exp_v;
      logic [OW-1:0] act_v;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act_v = {state_dbg, product_select, change_valid, token_reject, credit, busy};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs @%0t: actual st=%0d psel=%0d cv=%b rej=%b cr=%0d busy=%b required st=%0d psel=%0d cv=%b rej=%b cr=%0d busy=%b",
                     $time, act_v[11:10], act_v[9:7], act_v[6], act_v[5], act_v[4:1], act_v[0],
                     exp_v[11:10], exp_v[9:7], exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      #2;
      reset = 1'b1;
      #1;
      check("rst_psel",   int'(product_select), 0);
      check("rst_cv",     int'(change_valid),   0);
      check("rst_rej",    int'(token_reject),   0);
      check("rst_credit", int'(credit),         0);
      check("rst_busy",   int'(busy),           0);
      check("rst_state",  int'(state_dbg),      0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // exact-price purchase, no change afterwards
      tokens(1);
      cycle(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      nop(2);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      nop(1);

      // three tokens, product 1, one change token
      tokens(3);
      cycle(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      nop(1);

      // unaffordable candidates block higher-index buttons
      tokens(1);
      cycle(1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 3'b110, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      nop(1);

      // saturation and rejects while busy
      tokens(8);
      cycle(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // change held off by the hopper, then back-to-back handshakes
      tokens(5);
      cycle(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      nop(3);
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

`ifdef VEND_REFUND_EN
      tokens(2);
      cycle(1'b1, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tokens(2);
      cycle(1'b0, 3'b001, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
`endif

      // reset while change is outstanding
      tokens(4);
      cycle(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      nop(1);
      async_reset_check("midchg");
      nop(1);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         bit            r_tok;
         logic [NP-1:0] r_btn;
         bit            r_done;
         bit            r_rdy;
         bit            r_rf;
         r_tok  = ($urandom_range(0, 3) == 0);
         r_btn  = ($urandom_range(0, 2) == 0) ? NP'($urandom_range(1, 7)) : '0;
         r_done = ($urandom_range(0, 4) == 0);
         r_rdy  = ($urandom_range(0, 2) != 0);
`ifdef VEND_REFUND_EN
         r_rf   = ($urandom_range(0, 9) == 0);
`else
         r_rf   = 1'b0;
`endif
         cycle(r_tok, r_btn, r_done, r_rdy, r_rf);
      end
      nop(1);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
